// File: rtl/keypad_encoder.sv
// Keypad one-hot to binary encoder with two-flop synchronisation, debounce
// qualification, press strobe, key-down status and multi-hot rejection.
module keypad_encoder #(
    parameter int unsigned N             = 16,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned PRIORITY      = 0,
    localparam int unsigned CODE_W       = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      onehot,
    output logic [CODE_W-1:0] code,
    output logic              key_valid,
    output logic              key_down,
    output logic              err
);

    localparam int unsigned        CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [N-1:0]      sync1;
    logic [N-1:0]      s;
    logic [N-1:0]      cand;
    logic [N-1:0]      cand_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CODE_W-1:0] code_nx;
    logic              key_valid_nx;
    logic              key_down_nx;
    logic              err_nx;
    logic              cand_single_c;
    logic              cand_legal_c;
    logic [CODE_W-1:0] cand_index_c;

    // Lowest set index; for a single-hot vector this is simply its position.
    function automatic logic [CODE_W-1:0] lowest_index(input logic [N-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    assign cand_single_c = (cand != '0) && ((cand & (cand - N'(1))) == '0);
    assign cand_legal_c  = (PRIORITY != 0) || cand_single_c;
    assign cand_index_c  = lowest_index(cand);

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= onehot;
            s     <= sync1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            code      <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            code      <= code_nx;
            key_valid <= key_valid_nx;
            key_down  <= key_down_nx;
            err       <= err_nx;
        end
    end

    // Debounce sequencing, accept decision and release tracking.
    always_comb begin
        state_nx     = state;
        cand_nx      = cand;
        cnt_nx       = cnt;
        code_nx      = code;
        key_valid_nx = 1'b0;
        key_down_nx  = key_down;
        err_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (s != '0) begin
                    state_nx = QUAL;
                    cand_nx  = s;
                    cnt_nx   = CNT_ONE;
                end
            end

            QUAL: begin
                if (s == '0) begin
                    state_nx = IDLE;
                end else if (s != cand) begin
                    cand_nx = s;
                    cnt_nx  = CNT_ONE;
                end else if (cnt < CNT_LAST) begin
                    cnt_nx = cnt + CNT_ONE;
                end else begin
                    // Multi-hot still parks in HELD so a stuck pattern fires once.
                    state_nx = HELD;
                    if (cand_legal_c) begin
                        code_nx      = cand_index_c;
                        key_valid_nx = 1'b1;
                        key_down_nx  = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end

            HELD: begin
                if (s == '0) begin
                    state_nx = REL;
                    cnt_nx   = CNT_ONE;
                end else if (s != cand) begin
                    state_nx    = QUAL;
                    cand_nx     = s;
                    cnt_nx      = CNT_ONE;
                    key_down_nx = 1'b0;
                end
            end

            REL: begin
                if (s == '0) begin
                    if (cnt < CNT_LAST) begin
                        cnt_nx = cnt + CNT_ONE;
                    end else begin
                        state_nx    = IDLE;
                        key_down_nx = 1'b0;
                    end
                end else if (s == cand) begin
                    state_nx = HELD;
                end else begin
                    state_nx    = QUAL;
                    cand_nx     = s;
                    cnt_nx      = CNT_ONE;
                    key_down_nx = 1'b0;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: strict and priority instances driven
// in parallel, compared every cycle against a sample-run behavioural model.
module tb_keypad_encoder;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] onehot;
    logic [3:0]  code0, code1;
    logic        kv0, kv1, kd0, kd1, err0, err1;

    keypad_encoder #(.N(16), .STABLE_CYCLES(S), .PRIORITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .onehot(onehot),
        .code(code0), .key_valid(kv0), .key_down(kd0), .err(err0)
    );

    keypad_encoder #(.N(16), .STABLE_CYCLES(S), .PRIORITY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .onehot(onehot),
        .code(code1), .key_valid(kv1), .key_down(kd1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sync pipeline, run of identical samples, latched pattern.
    logic [15:0] q1, q2, run_pat;
    int          run_len;
    logic        lat[2];
    logic [15:0] lat_pat[2];
    logic [3:0]  m_code[2];
    logic        m_kv[2], m_kd[2], m_err[2];

    int edge_n;
    int kv_first[2], kv_cnt[2], err_cnt[2], kd_fall[2];

    function automatic logic [3:0] low_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q1 = '0; q2 = '0; run_pat = '0; run_len = 0;
        for (int p = 0; p < 2; p++) begin
            lat[p] = 1'b0; lat_pat[p] = '0; m_code[p] = '0;
            m_kv[p] = 1'b0; m_kd[p] = 1'b0; m_err[p] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [15:0] v);
        logic [15:0] x;
        x  = q2;
        q2 = q1;
        q1 = v;
        if (x == run_pat) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_pat = x;
            run_len = 1;
        end
        for (int p = 0; p < 2; p++) begin
            m_kv[p]  = 1'b0;
            m_err[p] = 1'b0;
            if (!lat[p]) begin
                if (x != 16'h0 && run_len == S) begin
                    lat[p]     = 1'b1;
                    lat_pat[p] = x;
                    if (p == 1 || $countones(x) == 1) begin
                        m_kv[p]   = 1'b1;
                        m_code[p] = low_idx(x);
                        m_kd[p]   = 1'b1;
                    end else begin
                        m_err[p] = 1'b1;
                    end
                end
            end else if (x == 16'h0) begin
                if (run_len == S) begin
                    lat[p]  = 1'b0;
                    m_kd[p] = 1'b0;
                end
            end else if (x != lat_pat[p]) begin
                lat[p]  = 1'b0;
                m_kd[p] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("code0", 32'(code0), 32'(m_code[0]));
        chk("kv0",   32'(kv0),   32'(m_kv[0]));
        chk("kd0",   32'(kd0),   32'(m_kd[0]));
        chk("err0",  32'(err0),  32'(m_err[0]));
        chk("code1", 32'(code1), 32'(m_code[1]));
        chk("kv1",   32'(kv1),   32'(m_kv[1]));
        chk("kd1",   32'(kd1),   32'(m_kd[1]));
        chk("err1",  32'(err1),  32'(m_err[1]));
    endtask

    task automatic clr();
        edge_n = 0;
        for (int p = 0; p < 2; p++) begin
            kv_first[p] = 0; kv_cnt[p] = 0; err_cnt[p] = 0; kd_fall[p] = 0;
        end
    endtask

    // One clock: drive, sample #1 after the edge, advance model, compare.
    task automatic cyc(input logic [15:0] v);
        onehot = v;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else        model_step(v);
        check_all();
        edge_n++;
        if (kv0) begin kv_cnt[0]++; if (kv_first[0] == 0) kv_first[0] = edge_n; end
        if (kv1) begin kv_cnt[1]++; if (kv_first[1] == 0) kv_first[1] = edge_n; end
        if (err0) err_cnt[0]++;
        if (err1) err_cnt[1]++;
        if (!kd0 && kd_fall[0] == 0) kd_fall[0] = edge_n;
        if (!kd1 && kd_fall[1] == 0) kd_fall[1] = edge_n;
    endtask

    initial begin
        int kind;
        int len;
        logic [15:0] pat;

        rst_n  = 1'b0;
        onehot = '0;
        model_reset();
        clr();
        repeat (3) cyc(16'h0);
        rst_n = 1'b1;
        repeat (3) cyc(16'h0);

        // Clean press and release
        clr();
        repeat (20) cyc(16'h0020);
        chk("press_lat", 32'(kv_first[0]), 32'd6);
        chk("press_cnt", 32'(kv_cnt[0]), 32'd1);
        chk("press_code", 32'(code0), 32'd5);
        chk("press_down", 32'(kd0), 32'd1);
        clr();
        repeat (12) cyc(16'h0);
        chk("release_lat", 32'(kd_fall[0]), 32'd6);
        chk("release_code", 32'(code0), 32'd5);

        // Multi-hot: strict instance rejects, priority instance takes lowest
        clr();
        repeat (20) cyc(16'h0840);
        chk("mh_err0", 32'(err_cnt[0]), 32'd1);
        chk("mh_kv0", 32'(kv_cnt[0]), 32'd0);
        chk("mh_code0", 32'(code0), 32'd5);
        chk("mh_down0", 32'(kd0), 32'd0);
        chk("mh_kv1", 32'(kv_cnt[1]), 32'd1);
        chk("mh_code1", 32'(code1), 32'd6);
        chk("mh_err1", 32'(err_cnt[1]), 32'd0);
        repeat (12) cyc(16'h0);

        // Bounce, then stable hold
        clr();
        for (int i = 0; i < 10; i++) cyc(((i / 2) % 2 == 1) ? 16'h0100 : 16'h0000);
        chk("bounce_kv", 32'(kv_cnt[0]), 32'd0);
        clr();
        repeat (20) cyc(16'h0100);
        chk("bounce_lat", 32'(kv_first[0]), 32'd6);
        chk("bounce_cnt", 32'(kv_cnt[0]), 32'd1);
        chk("bounce_code", 32'(code0), 32'd8);
        repeat (12) cyc(16'h0);

        // Rollover
        repeat (10) cyc(16'h0002);
        chk("roll_first", 32'(code0), 32'd1);
        clr();
        repeat (15) cyc(16'h8000);
        chk("roll_drop", 32'(kd_fall[0]), 32'd3);
        chk("roll_lat", 32'(kv_first[0]), 32'd6);
        chk("roll_code", 32'(code0), 32'd15);
        repeat (12) cyc(16'h0);

        // Reset while qualifying
        repeat (4) cyc(16'h0004);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_code", 32'(code0), 32'd0);
        chk("rst_kv", 32'(kv0), 32'd0);
        chk("rst_down", 32'(kd0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        repeat (3) cyc(16'h0004);
        rst_n = 1'b1;
        clr();
        repeat (12) cyc(16'h0004);
        chk("rst_lat", 32'(kv_first[0]), 32'd6);
        chk("rst_code2", 32'(code0), 32'd2);
        repeat (12) cyc(16'h0);

        // Randomised segments of idle, single keys and multi-hot chords
        for (int seg = 0; seg < 80; seg++) begin
            kind = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 9));
            pat  = 16'h1 << $urandom_range(0, 15);
            if (kind == 0) pat = 16'h0;
            else if (kind == 3) pat = pat | (16'h1 << $urandom_range(0, 15));
            repeat (len) cyc(pat);
        end
        repeat (12) cyc(16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Parametrised successor to the keypad one-hot encoder.
- Converts an N-line keypad one-hot vector into a binary key code, with input synchronisation, debounce qualification, press-event strobe, key-down status and multi-hot error detection.
- Sits between the keypad scanner and the display/control logic.
- The last accepted code is held until a new key is accepted.

Parameters:
- N, 16, number of key lines (2..64).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required to accept a press or release (2..255).
- PRIORITY, 0, multi-hot handling: 0 = strict one-hot (multi-hot is an error), 1 = lowest set index wins.
- CODE_W, $clog2(N), derived code width (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- onehot  input  N  raw key lines, asynchronous to clk, bit i = key i pressed.
- code  output  CODE_W  binary index of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_down  output  1  high while an accepted key is held.
- err  output  1  one-cycle pulse when a qualified multi-hot pattern is rejected (PRIORITY=0 only).

Behaviour:
- Reset (rst_n low, async): code=0, key_valid=0, key_down=0, err=0, state=IDLE, counter=0, candidate=0, synchroniser flops=0.
- Synchroniser: onehot passes through a two-flop synchroniser. Its output s drives the FSM.
- Counter: width $clog2(STABLE_CYCLES+1). It never wraps and saturates at STABLE_CYCLES-1.
- IDLE:
  - s!=0: go to QUAL, candidate<=s, cnt<=1.
  - Else stay.
- QUAL:
  - s==0: go to IDLE.
  - s!=0 and s!=candidate: candidate<=s, cnt<=1 (restart).
  - s==candidate and cnt<STABLE_CYCLES-1: cnt++.
  - s==candidate and cnt==STABLE_CYCLES-1: accept. The pattern is qualified and the FSM goes to HELD.
- Accept rules:
  - Legal pattern (exactly one bit set; or any nonzero pattern when PRIORITY=1): code<=index of the set bit (PRIORITY=1: lowest set index), key_valid<=1 for one cycle, key_down<=1.
  - Illegal pattern (PRIORITY=0, two or more bits set): err<=1 for one cycle. code and key_down are unchanged. The FSM still enters HELD, so a stuck multi-hot pattern does not re-fire.
- HELD:
  - s==candidate: stay.
  - s==0: go to REL, cnt<=1.
  - s nonzero and different (rollover): go to QUAL, candidate<=s, cnt<=1, key_down<=0.
- REL:
  - s==0 and cnt<STABLE_CYCLES-1: cnt++.
  - s==0 and cnt==STABLE_CYCLES-1: go to IDLE, key_down<=0.
  - s==candidate: return to HELD (release bounce). No new key_valid.
  - s nonzero and different: go to QUAL, candidate<=s, cnt<=1, key_down<=0.
- Latency:
  - New pattern stable at onehot before edge E0: key_valid is high in the cycle after edge E(STABLE_CYCLES+1). For STABLE_CYCLES=4 that is the 6th sampling edge.
  - Release: key_down falls STABLE_CYCLES+2 edges after onehot returns to 0.
- Code holding: code changes only on a legal accept. Release, err, bounce and rollover never alter code.
- key_valid and err are never high in the same cycle. Neither output is registered-high for more than one cycle per accept.
- Reset mid-operation: all state clears immediately. After rst_n deasserts, a still-pressed key is treated as a new press and produces key_valid after the full latency.
- Unused states (if the encoding has spares) fall back to IDLE.

Test Plan:
- Clean press: N=16, S=4. Drive onehot=16'h0020 for 20 cycles, then 0 -> key_valid pulses once on the 6th edge with code=5, key_down=1. key_down falls 6 edges after release. code stays 5 afterwards.
- Bounce: toggle onehot between 16'h0100 and 0 every 2 cycles for 10 cycles, then hold 16'h0100 -> no key_valid during bouncing. Exactly one key_valid with code=8, S+2 edges after the final stable edge.
- Multi-hot, PRIORITY=0: previous code=5. Hold onehot=16'h0840 -> one err pulse, no key_valid, code stays 5, key_down stays 0.
- Multi-hot, PRIORITY=1: hold onehot=16'h0840 -> key_valid with code=6, err never asserted.
- Rollover: hold 16'h0002 until accepted, then switch directly to 16'h8000 -> key_down drops, then a second key_valid arrives with code=15 after S qualifying samples.
- Reset mid-press: assert rst_n=0 during QUAL with 16'h0004 held, release after 3 cycles -> all outputs 0 immediately. key_valid with code=2 follows S+2 edges after rst_n rises.
